// File: rtl/la_pattern_gen.sv
// Test-pattern source for the logic-analyser capture path: divides sys_clk into data_clk
// and steps a DATA_W-bit pattern (rotate / LFSR / counter / walking-one) once per period.
module la_pattern_gen #(
    parameter int                DATA_W  = 8,
    parameter int                DIV_W   = 32,
    parameter logic [DIV_W-1:0]  DIV_DEF = DIV_W'(1000),
    parameter logic [DATA_W-1:0] SEED    = DATA_W'(8'h88),
    parameter logic [DATA_W-1:0] TAPS    = DATA_W'(8'hB8)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed,
    output logic              data_clk,
    output logic              data_valid,
    output logic [DATA_W-1:0] test_data
);

    typedef enum logic [1:0] {
        MODE_ROT  = 2'd0,
        MODE_LFSR = 2'd1,
        MODE_CNT  = 2'd2,
        MODE_WALK = 2'd3
    } mode_e;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] p_act;

    logic cnt_wrap;
    logic cnt_half;
    logic cnt_upd;

    assign cnt_wrap = (cnt == p_act);
    assign cnt_half = (cnt == (p_act >> 1));
    assign cnt_upd  = (cnt == (p_act - DIV_W'(1)));

    // Terminal counts below 2 would collapse the half/update/wrap points onto each other.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    function automatic logic [DATA_W-1:0] next_pat(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        m);
        logic [DATA_W-1:0] r;
        logic              one_hot;
        one_hot = (d != '0) && ((d & (d - DATA_W'(1))) == '0);
        case (mode_e'(m))
            MODE_ROT:  r = {d[DATA_W-2:0], d[DATA_W-1]};
            MODE_LFSR: r = (d == '0) ? DATA_W'(1) : {d[DATA_W-2:0], ^(d & TAPS)};
            MODE_CNT:  r = d + DATA_W'(1);
            default:   r = (one_hot && !d[DATA_W-1]) ? (d << 1) : DATA_W'(1);
        endcase
        return r;
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt        <= '0;
            p_act      <= DIV_DEF;
            data_clk   <= 1'b1;
            data_valid <= 1'b0;
            test_data  <= SEED;
        end else if (seed_load) begin
            cnt        <= '0;
            p_act      <= clamp_div(div_val);
            data_clk   <= 1'b1;
            data_valid <= 1'b0;
            test_data  <= seed;
        end else if (!en) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= cnt_upd;
            if (cnt_upd)
                test_data <= next_pat(test_data, mode);
            if (cnt_half)
                data_clk <= 1'b0;
            // div_val is only sampled at the wrap so a period never changes length mid-flight.
            if (cnt_wrap) begin
                cnt      <= '0;
                p_act    <= clamp_div(div_val);
                data_clk <= 1'b1;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_la_pattern_gen.sv
// Self-checking bench for la_pattern_gen: per-cycle compare against a behavioural model,
// directed literal checks for each mode and divider corner, then randomized traffic.
module tb_la_pattern_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] div_val;
    logic        seed_load;
    logic [7:0]  seed;
    logic        data_clk;
    logic        data_valid;
    logic [7:0]  test_data;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    la_pattern_gen dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .mode       (mode),
        .div_val    (div_val),
        .seed_load  (seed_load),
        .seed       (seed),
        .data_clk   (data_clk),
        .data_valid (data_valid),
        .test_data  (test_data)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position within the period, period length, pattern.
    int unsigned m_pos;
    int unsigned m_per;
    bit          m_valid;
    logic [7:0]  m_data;

    function automatic logic [7:0] model_next(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'd0: return 8'((d << 1) | (d >> 7));
            2'd1: return (d == 8'd0) ? 8'd1 : 8'((d << 1) | 8'($countones(d & 8'hB8) % 2));
            2'd2: return 8'(d + 8'd1);
            default: return ($countones(d) == 1 && d < 8'h80) ? 8'(d * 2) : 8'd1;
        endcase
    endfunction

    function automatic int unsigned eff_div(input logic [31:0] v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_pos = 0; m_per = 1000; m_valid = 0; m_data = 8'h88;
        end else if (seed_load) begin
            m_pos = 0; m_per = eff_div(div_val); m_valid = 0; m_data = seed;
        end else if (!en) begin
            m_valid = 0;
        end else begin
            m_valid = (m_pos + 1 == m_per);
            if (m_valid) m_data = model_next(m_data, mode);
            if (m_pos == m_per) begin
                m_pos = 0;
                m_per = eff_div(div_val);
            end else begin
                m_pos++;
            end
        end
    end

    // data_clk is high through the first half of the period (positions 0..P/2), low after.
    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("model_data_clk", {31'd0, data_clk}, {31'd0, (m_pos <= (m_per >> 1))});
            check("model_valid", {31'd0, data_valid}, {31'd0, m_valid});
            check("model_data", {24'd0, test_data}, {24'd0, m_data});
        end
    end

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (!data_valid && cyc < max);
    endtask

    task automatic upd(input string name, input int exp_cyc, input logic [7:0] exp_data,
                       input bit chk_data);
        int c;
        wait_valid(exp_cyc + 50, c);
        check({name, "_cyc"}, c, exp_cyc);
        if (chk_data) check({name, "_data"}, {24'd0, test_data}, {24'd0, exp_data});
    endtask

    task automatic load(input logic [7:0] s, input logic [31:0] d);
        seed_load = 1'b1; seed = s; div_val = d;
        @(negedge sys_clk);
        seed_load = 1'b0;
    endtask

    initial begin
        int c, n;
        logic [7:0] walk;
        sys_rst = 1'b1; en = 1'b0; mode = 2'd0; div_val = 1000; seed_load = 1'b0; seed = 8'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_data_clk", {31'd0, data_clk}, 32'd1);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_data", {24'd0, test_data}, 32'h88);
        sys_rst = 1'b0; en = 1'b1; chk_on = 1'b1;

        // rotate from reset seed, default divider
        upd("rot1", 1000, 8'h11, 1);
        upd("rot2", 1001, 8'h22, 1);
        upd("rot3", 1001, 8'h44, 1);
        upd("rot4", 1001, 8'h88, 1);

        // LFSR full cycle and zero escape
        mode = 2'd1;
        load(8'h01, 3);
        upd("lfsr1", 3, 8'h02, 1);
        upd("lfsr2", 4, 8'h04, 1);
        upd("lfsr3", 4, 8'h08, 1);
        upd("lfsr4", 4, 8'h11, 1);
        upd("lfsr5", 4, 8'h23, 1);
        n = 5;
        do begin
            wait_valid(10, c);
            n++;
        end while (test_data != 8'h01 && n < 300);
        check("lfsr_len", n, 255);
        load(8'h00, 3);
        upd("lfsr_zero", 3, 8'h01, 1);

        // counter wrap, walking one
        mode = 2'd2;
        load(8'hFE, 3);
        upd("cnt_ff", 3, 8'hFF, 1);
        upd("cnt_wrap", 4, 8'h00, 1);
        mode = 2'd3;
        load(8'h05, 3);
        upd("walk_fix", 3, 8'h01, 1);
        walk = 8'h01;
        for (int i = 0; i < 8; i++) begin
            walk = (walk == 8'h80) ? 8'h01 : 8'(walk << 1);
            upd("walk", 4, walk, 1);
        end

        // divider change mid-period and clamp
        mode = 2'd0;
        load(8'h88, 1000);
        repeat (200) @(negedge sys_clk);
        div_val = 10;
        upd("div_old", 800, 8'h11, 1);
        upd("div_new1", 11, 8'h22, 1);
        upd("div_new2", 11, 8'h44, 1);
        div_val = 0;
        upd("div_min1", 3, 8'h88, 1);
        upd("div_min2", 3, 8'h11, 1);

        // freeze
        load(8'h88, 1000);
        repeat (400) @(negedge sys_clk);
        en = 1'b0;
        repeat (50) @(negedge sys_clk);
        en = 1'b1;
        upd("freeze", 600, 8'h11, 1);

        // seed_load coincident with update, then async reset mid-period
        load(8'h88, 1000);
        repeat (999) @(negedge sys_clk);
        load(8'hA5, 1000);
        check("coll_data", {24'd0, test_data}, 32'hA5);
        check("coll_valid", {31'd0, data_valid}, 32'd0);
        check("coll_clk", {31'd0, data_clk}, 32'd1);
        upd("coll_next", 1000, 8'h4B, 1);
        repeat (700) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_clk", {31'd0, data_clk}, 32'd1);
        check("arst_data", {24'd0, test_data}, 32'h88);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            mode      = 2'($urandom_range(0, 3));
            div_val   = $urandom_range(0, 12);
            seed_load = ($urandom_range(0, 99) == 0);
            seed      = 8'($urandom);
            @(negedge sys_clk);
        end
        seed_load = 1'b0;
        @(negedge sys_clk);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
